buffer_reader: RTL and testbench

Streaming read-side controller for the dual-port sample buffer RAM. It takes a frame descriptor (start address, word count), drives the RAM read address and absorbs the RAM's one-cycle registered read latency. It delivers the words as a valid/ready stream with full backpressure support and frame-last marking. It sits between the buffer RAM and the downstream DSP/transmit chain, opposite the writer that fills the buffer.

---
 rtl/buffer_pkg.sv | 26 ++
 rtl/buffer_reader_skid.sv | 70 +++++++
 rtl/buffer_reader.sv | 205 ++++++++++++++++++++
 tb/tb_buffer_reader.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/buffer_pkg.sv
// buffer_pkg
// Shared types for the buffer read-side controller.
//   DEF_DATA_W / DEF_ADDR_W : default word and address widths
//   state_e                 : reader FSM states
//   entry_t                 : one skid FIFO slot (word + frame-last tag)
// The skid FIFO entry is sized from DEF_DATA_W, so buffer_reader must be
// built with DATA_W equal to DEF_DATA_W.

package buffer_pkg;

   localparam int DEF_DATA_W = 24;
   localparam int DEF_ADDR_W = 18;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef struct packed {
      logic [DEF_DATA_W-1:0] data;
      logic                  last;
   } entry_t;

endpackage

// File: rtl/buffer_reader_skid.sv
// buffer_reader_skid
// Two-entry synchronous FIFO with first-word-fall-through output. It holds
// RAM words that have come back but not yet been taken by the stream sink.
// Ports:
//   iclk, irst_n : clock, synchronous active-low reset (empties the FIFO)
//   push         : write push_entry this cycle
//   push_entry   : word + last tag to store
//   pop          : remove the head entry this cycle (ignored when empty)
//   head         : current head entry (meaningful only when count != 0)
//   count        : occupancy, 0..2
// A push while full is allowed only together with a pop; the caller's
// credit logic keeps it from happening otherwise.

module buffer_reader_skid
   import buffer_pkg::*;
(
   input  logic       iclk,
   input  logic       irst_n,
   input  logic       push,
   input  entry_t     push_entry,
   input  logic       pop,
   output entry_t     head,
   output logic [1:0] count
);

   entry_t [1:0] mem_q, mem_d;
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   count_q, count_d;
   logic         do_push, do_pop;

   always_comb begin
      do_pop   = pop && (count_q != 2'd0);
      do_push  = push && ((count_q != 2'd2) || do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_entry;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge iclk) begin
      if (!irst_n) begin
         mem_q    <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/buffer_reader.sv
// buffer_reader
// Streaming read-side controller for the dual-port sample buffer. Takes a
// frame descriptor (start address, word count), walks the RAM read address,
// absorbs the RAM's one-cycle read latency in a 2-entry skid FIFO and
// delivers the words as a valid/ready stream with a frame-last tag.
// Ports:
//   iclk, irst_n        : clock (shared with the RAM), sync active-low reset
//   istart              : start pulse, sampled only in IDLE
//   istart_addr, ilen   : frame descriptor; ilen may be 0..2**ADDR_W
//   r_addr              : RAM read address
//   iram_data           : RAM read data, valid one cycle after r_addr
//   odata/ovalid/iready : output stream
//   olast               : tags the final word of a frame (or pass)
//   obusy               : high while a frame is being read out
//   odone               : one-cycle pulse after the last word is accepted
//   istop               : only with BUFFER_READER_LOOP_EN; ends looping
// Build option BUFFER_READER_LOOP_EN: repeat the frame until istop is seen.
//
// state | meaning
// IDLE  | waiting for istart
// READ  | issuing one RAM read per cycle while credit allows
// DRAIN | all addresses issued, waiting for the final word to be taken
// DONE  | odone pulse, back to IDLE next cycle

module buffer_reader
   import buffer_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              iclk,
   input  logic              irst_n,
   input  logic              istart,
   input  logic [ADDR_W-1:0] istart_addr,
   input  logic [ADDR_W:0]   ilen,
   output logic [ADDR_W-1:0] r_addr,
   input  logic [DATA_W-1:0] iram_data,
   output logic [DATA_W-1:0] odata,
   output logic              ovalid,
   input  logic              iready,
   output logic              olast,
   output logic              obusy,
   output logic              odone
`ifdef BUFFER_READER_LOOP_EN
   ,
   input  logic              istop
`endif
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] r_addr_q, r_addr_d;
   logic [ADDR_W:0]   rem_q, rem_d;
   logic              inflight_q, inflight_d;
   logic              inflight_last_q, inflight_last_d;

`ifdef BUFFER_READER_LOOP_EN
   logic [ADDR_W-1:0] start_addr_q, start_addr_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic              stop_seen_q, stop_seen_d;
`endif

   entry_t     push_entry;
   entry_t     head;
   logic [1:0] count;
   logic       fifo_valid;
   logic       pop;
   logic [1:0] occ;
   logic       credit_ok;
   logic       last_issue;
   logic       stop_now;

   buffer_reader_skid u_skid (
      .iclk       (iclk),
      .irst_n     (irst_n),
      .push       (inflight_q),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .count      (count)
   );

   always_comb begin
      push_entry.data = iram_data;
      push_entry.last = inflight_last_q;
   end

   always_comb begin
      fifo_valid = (count != 2'd0);
      pop        = fifo_valid && iready;
      // Words already in the FIFO plus the one coming back from the RAM;
      // a pop this cycle frees one slot before the new read lands.
      occ        = count + {1'b0, inflight_q};
      credit_ok  = pop ? (occ < 2'd3) : (occ < 2'd2);
      last_issue = (rem_q == (ADDR_W+1)'(1));
`ifdef BUFFER_READER_LOOP_EN
      stop_now   = stop_seen_q || istop;
`else
      stop_now   = 1'b1;
`endif
   end

   always_comb begin
      state_d         = state_q;
      r_addr_d        = r_addr_q;
      rem_d           = rem_q;
      inflight_d      = 1'b0;
      inflight_last_d = 1'b0;
`ifdef BUFFER_READER_LOOP_EN
      start_addr_d    = start_addr_q;
      len_d           = len_q;
      stop_seen_d     = stop_seen_q ||
                        (istop && ((state_q == READ) || (state_q == DRAIN)));
`endif

      case (state_q)
         IDLE: begin
            if (istart) begin
               r_addr_d = istart_addr;
               rem_d    = ilen;
`ifdef BUFFER_READER_LOOP_EN
               start_addr_d = istart_addr;
               len_d        = ilen;
               stop_seen_d  = 1'b0;
`endif
               state_d  = (ilen == '0) ? DONE : READ;
            end
         end

         READ: begin
            if (credit_ok) begin
               inflight_d      = 1'b1;
               inflight_last_d = last_issue;
               r_addr_d        = r_addr_q + ADDR_W'(1);
               rem_d           = rem_q - (ADDR_W+1)'(1);
               if (last_issue) begin
                  if (stop_now) begin
                     state_d = DRAIN;
                  end
`ifdef BUFFER_READER_LOOP_EN
                  else begin
                     r_addr_d    = start_addr_q;
                     rem_d       = len_q;
                     stop_seen_d = 1'b0;
                  end
`endif
               end
            end
         end

         DRAIN: begin
            // Final word leaving with nothing behind it; earlier pass-end
            // words may still sit in the FIFO in loop mode.
            if (pop && head.last && (count == 2'd1) && !inflight_q) begin
               state_d = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge iclk) begin
      if (!irst_n) begin
         state_q         <= IDLE;
         r_addr_q        <= '0;
         rem_q           <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         r_addr_q        <= r_addr_d;
         rem_q           <= rem_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
      end
   end

`ifdef BUFFER_READER_LOOP_EN
   always_ff @(posedge iclk) begin
      if (!irst_n) begin
         start_addr_q <= '0;
         len_q        <= '0;
         stop_seen_q  <= 1'b0;
      end else begin
         start_addr_q <= start_addr_d;
         len_q        <= len_d;
         stop_seen_q  <= stop_seen_d;
      end
   end
`endif

   assign r_addr = r_addr_q;
   assign ovalid = fifo_valid;
   assign odata  = fifo_valid ? head.data : '0;
   assign olast  = fifo_valid && head.last;
   assign obusy  = (state_q == READ) || (state_q == DRAIN);
   assign odone  = (state_q == DONE);

endmodule

// File: tb/tb_buffer_reader.sv
// tb_buffer_reader
// Directed bench for buffer_reader: behavioural RAM with a known word
// pattern, frame runner with selectable ready pattern, reset and busy-start
// cases. Loop-mode case is built only with BUFFER_READER_LOOP_EN.

module tb_buffer_reader;

   localparam int DW = 24;
   localparam int AW = 18;

   logic          iclk = 1'b0;
   logic          irst_n;
   logic          istart;
   logic [AW-1:0] istart_addr;
   logic [AW:0]   ilen;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] iram_data = '0;
   logic [DW-1:0] odata;
   logic          ovalid;
   logic          iready;
   logic          olast;
   logic          obusy;
   logic          odone;
`ifdef BUFFER_READER_LOOP_EN
   logic          istop = 1'b0;
`endif

   int n_checks = 0;
   int n_errors = 0;

   buffer_reader dut (
      .iclk        (iclk),
      .irst_n      (irst_n),
      .istart      (istart),
      .istart_addr (istart_addr),
      .ilen        (ilen),
      .r_addr      (r_addr),
      .iram_data   (iram_data),
      .odata       (odata),
      .ovalid      (ovalid),
      .iready      (iready),
      .olast       (olast),
      .obusy       (obusy),
      .odone       (odone)
`ifdef BUFFER_READER_LOOP_EN
      ,
      .istop       (istop)
`endif
   );

   always #5 iclk = ~iclk;

   function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
      return {a[5:0], a} ^ 24'h5A5A5A;
   endfunction

   always @(posedge iclk) iram_data <= ram_word(r_addr);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic ready_pat(input int pat, input int c);
      if (pat == 1) return ((c % 3) == 2);
      return 1'b1;
   endfunction

   // Pulses istart, then runs until odone (bounded). Cycle c=0 is the cycle
   // after the edge that samples istart.
   task automatic run_frame(input string tag, input logic [AW-1:0] sa,
                            input logic [AW:0] len, input int pat,
                            input int restart_cyc, input int stop_cyc,
                            input int passes);
      int            n_exp, n_got, idx, len_i;
      int            hs_last_cyc, first_valid_cyc, done_cyc;
      logic          prev_stall, prev_last, exp_last;
      logic [DW-1:0] prev_data;
      logic [AW-1:0] a;
      len_i           = int'(len);
      n_exp           = len_i * passes;
      n_got           = 0;
      hs_last_cyc     = -1;
      first_valid_cyc = -1;
      done_cyc        = -1;
      prev_stall      = 1'b0;
      prev_last       = 1'b0;
      prev_data       = '0;
      istart_addr     = sa;
      ilen            = len;
      istart          = 1'b1;
      @(posedge iclk); #1;
      istart = 1'b0;
      for (int c = 0; c < 400 && done_cyc < 0; c++) begin
         iready = ready_pat(pat, c);
         if (c == restart_cyc) begin
            istart      = 1'b1;
            istart_addr = ~sa;
            ilen        = (AW+1)'(2);
         end else begin
            istart = 1'b0;
         end
`ifdef BUFFER_READER_LOOP_EN
         istop = (c == stop_cyc);
`endif
         if (c == 0) chk({tag, " r_addr_first"}, 32'(r_addr), 32'(sa));
         @(negedge iclk);
         if (prev_stall) begin
            chk({tag, " hold_valid"}, 32'(ovalid), 32'd1);
            chk({tag, " hold_data"}, 32'(odata), 32'(prev_data));
            chk({tag, " hold_last"}, 32'(olast), 32'(prev_last));
         end
         if (ovalid && first_valid_cyc < 0) first_valid_cyc = c;
         if (ovalid && iready) begin
            idx      = (len_i == 0) ? 0 : (n_got % len_i);
            a        = sa + AW'(idx);
            exp_last = (len_i != 0) && (((n_got + 1) % len_i) == 0);
            chk({tag, " data"}, 32'(odata), 32'(ram_word(a)));
            chk({tag, " last"}, 32'(olast), 32'(exp_last));
            if (olast) hs_last_cyc = c;
            n_got++;
         end
         if (odone) begin
            done_cyc = c;
            chk({tag, " busy_at_done"}, 32'(obusy), 32'd0);
         end
         prev_stall = ovalid && !iready;
         prev_data  = odata;
         prev_last  = olast;
         @(posedge iclk); #1;
      end
      istart = 1'b0;
`ifdef BUFFER_READER_LOOP_EN
      istop = 1'b0;
`endif
      chk({tag, " done_seen"}, 32'(done_cyc >= 0), 32'd1);
      chk({tag, " word_count"}, 32'(n_got), 32'(n_exp));
      if (len_i == 0) begin
         chk({tag, " zero_done_cyc"}, 32'(done_cyc), 32'd0);
         chk({tag, " zero_no_valid"}, 32'(first_valid_cyc), 32'hFFFFFFFF);
      end else begin
         chk({tag, " first_valid_cyc"}, 32'(first_valid_cyc), 32'd2);
         chk({tag, " done_after_last"}, 32'(done_cyc), 32'(hs_last_cyc + 1));
      end
      chk({tag, " idle_after"}, {30'd0, obusy, ovalid}, 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " r_addr"}, 32'(r_addr), 32'd0);
      chk({tag, " odata"}, 32'(odata), 32'd0);
      chk({tag, " ovalid"}, 32'(ovalid), 32'd0);
      chk({tag, " olast"}, 32'(olast), 32'd0);
      chk({tag, " obusy"}, 32'(obusy), 32'd0);
      chk({tag, " odone"}, 32'(odone), 32'd0);
   endtask

   initial begin
      irst_n      = 1'b0;
      istart      = 1'b0;
      istart_addr = '0;
      ilen        = '0;
      iready      = 1'b1;
      repeat (3) @(posedge iclk);
      #1;
      chk_reset_outputs("reset");
      irst_n = 1'b1;
      @(posedge iclk); #1;

      run_frame("basic", 18'h00010, 19'd4, 0, -1, -1, 1);
      run_frame("wrap", 18'h3FFFE, 19'd4, 0, -1, -1, 1);
      run_frame("bp", 18'h00400, 19'd16, 1, -1, -1, 1);
      run_frame("zero", 18'h00123, 19'd0, 0, -1, -1, 1);
      run_frame("busy", 18'h00200, 19'd8, 0, 3, -1, 1);
      run_frame("one", 18'h3FFFF, 19'd1, 1, -1, -1, 1);

      // Reset while the third word of a 10-word frame is on the stream.
      iready      = 1'b1;
      istart_addr = 18'h00100;
      ilen        = 19'd10;
      istart      = 1'b1;
      @(posedge iclk); #1;
      istart = 1'b0;
      repeat (4) begin
         @(posedge iclk); #1;
      end
      @(negedge iclk);
      chk("midrst word3_valid", 32'(ovalid), 32'd1);
      chk("midrst word3_data", 32'(odata), 32'(ram_word(18'h00102)));
      irst_n = 1'b0;
      @(posedge iclk); #1;
      chk_reset_outputs("midrst");
      irst_n = 1'b1;
      @(posedge iclk); #1;
      chk_reset_outputs("midrst_idle");
      run_frame("after_rst", 18'h00030, 19'd5, 0, -1, -1, 1);

`ifdef BUFFER_READER_LOOP_EN
      run_frame("loop", 18'h00020, 19'd3, 0, -1, 4, 2);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
